parity_frame_tx: RTL and testbench

Serial framer that sits directly downstream of the 4-bit parity generator. It accepts a nibble and its parity bit through a valid/ready handshake and shifts out one 7-bit frame on a single wire: start bit, data bits LSB first, parity bit, stop bit. It also re-checks the incoming parity, counts completed frames, and pulses a completion strobe per frame.

---
 rtl/parity_frame_tx_if.sv | 28 ++
 rtl/parity_frame_tx.sv | 143 ++++++++++++++
 tb/tb_parity_frame_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/parity_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_tx_if
// Brief    : Nibble/parity handshake and serial-line bundle for parity_frame_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface parity_frame_tx_if;
    logic [3:0] d_in;
    logic       parity_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic       par_err;
    logic [7:0] frame_count;

    modport master (
        output d_in, parity_in, valid_in,
        input  ready_out, tx_out, busy, done, par_err, frame_count
    );

    modport slave (
        input  d_in, parity_in, valid_in,
        output ready_out, tx_out, busy, done, par_err, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_tx
// Brief    : 7-bit serial framer (start, 4 data LSB first, parity, stop) with
//            parity re-check, frame counter and completion strobe.
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    parity_frame_tx_if.slave       bus
);

    localparam logic [7:0] C_BIT_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q,   state_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [1:0] idx_q,     idx_d;
    logic [3:0] data_q,    data_d;
    logic       par_q,     par_d;
    logic       tx_q,      tx_d;
    logic       done_q,    done_d;
    logic       par_err_q, par_err_d;
    logic [7:0] count_q,   count_d;

    logic       bit_end;
    logic [1:0] idx_next;

    assign bit_end  = (cnt_q == C_BIT_LAST);
    assign idx_next = idx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= 2'd0;
            data_q    <= 4'd0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
            count_q   <= count_d;
        end
    end

    // tx_d is the level of the bit that the next state will be sending, so the
    // registered line changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        par_err_d = par_err_q;
        count_d   = count_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? 8'd0 : (cnt_q + 8'd1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.valid_in) begin
                    data_d    = bus.d_in;
                    par_d     = bus.parity_in;
                    par_err_d = par_err_q | (bus.parity_in ^ (^bus.d_in));
                    cnt_d     = 8'd0;
                    idx_d     = 2'd0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 2'd0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 2'd3) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_next;
                        tx_d  = data_q[idx_next];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_out   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.tx_out      = tx_q;
    assign bus.done        = done_q;
    assign bus.par_err     = par_err_q;
    assign bus.frame_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_tx
// Brief    : Directed, table-driven bench for parity_frame_tx (C=4 and C=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

    localparam int C_C4 = 4;

    typedef struct {
        logic [3:0] d;
        logic       p;
        bit         keep;   // hold valid_in high into the next frame
        logic [6:0] bits;   // [6] = start bit ... [0] = stop bit
        logic       perr;
        logic [7:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst1 = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    parity_frame_tx_if bus4();
    parity_frame_tx_if bus1();

    parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
    parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered on a falling edge; returns on the falling edge of cycle E+7C.
    task automatic run_frame(input vec_t v, input string tag);
        int guard = 0;
        while (!bus4.ready_out && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s_ready_before", tag), {31'd0, bus4.ready_out}, 32'd1);
        bus4.d_in      = v.d;
        bus4.parity_in = v.p;
        bus4.valid_in  = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 7; b++) begin
            for (int k = 0; k < C_C4; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) begin
                    bus4.valid_in = v.keep;
                    check($sformatf("%s_par_err_at_E", tag), {31'd0, bus4.par_err}, {31'd0, v.perr});
                end
                check($sformatf("%s_tx_b%0d_c%0d", tag, b, k), {31'd0, bus4.tx_out}, {31'd0, v.bits[6-b]});
                check($sformatf("%s_busy_ready_done_b%0d_c%0d", tag, b, k),
                      {29'd0, bus4.busy, bus4.ready_out, bus4.done}, 32'b100);
            end
        end
        @(negedge clk);
        check($sformatf("%s_end_busy_ready_done_tx", tag),
              {28'd0, bus4.busy, bus4.ready_out, bus4.done, bus4.tx_out}, 32'b0111);
        check($sformatf("%s_frame_count", tag), {24'd0, bus4.frame_count}, {24'd0, v.cnt});
        check($sformatf("%s_par_err_end", tag), {31'd0, bus4.par_err}, {31'd0, v.perr});
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        int   errs;
        int   ndone;
        int   pos;
        logic exp_tx;
        logic [6:0] pat;

        vecs[0] = '{d: 4'b0011, p: 1'b0, keep: 1'b0, bits: 7'b0110001, perr: 1'b0, cnt: 8'd1};
        vecs[1] = '{d: 4'b1011, p: 1'b1, keep: 1'b1, bits: 7'b0110111, perr: 1'b0, cnt: 8'd2};
        vecs[2] = '{d: 4'b1111, p: 1'b0, keep: 1'b0, bits: 7'b0111101, perr: 1'b0, cnt: 8'd3};
        vecs[3] = '{d: 4'b1011, p: 1'b0, keep: 1'b0, bits: 7'b0110101, perr: 1'b1, cnt: 8'd4};
        vecs[4] = '{d: 4'b0101, p: 1'b0, keep: 1'b0, bits: 7'b0101001, perr: 1'b1, cnt: 8'd5};

        bus4.d_in = 4'd0; bus4.parity_in = 1'b0; bus4.valid_in = 1'b0;
        bus1.d_in = 4'd0; bus1.parity_in = 1'b0; bus1.valid_in = 1'b0;

        // Reset asserted before any clock edge: outputs must settle asynchronously.
        #1;
        rst4 = 1'b1;
        rst1 = 1'b1;
        #1;
        check("reset4_outputs",
              {23'd0, bus4.tx_out, bus4.ready_out, bus4.busy, bus4.done, bus4.par_err, bus4.frame_count},
              {23'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        check("reset1_outputs",
              {23'd0, bus1.tx_out, bus1.ready_out, bus1.busy, bus1.done, bus1.par_err, bus1.frame_count},
              {23'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        rst4 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].keep) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check($sformatf("vec%0d_idle_tx_done", i), {30'd0, bus4.tx_out, bus4.done}, 32'b10);
                end
            end
        end

        // Abort during data bit 2 of 4'b1011 (bit value 0, so the line visibly jumps high).
        bus4.d_in = 4'b1011; bus4.parity_in = 1'b1; bus4.valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.valid_in = 1'b0;
        for (int k = 0; k < 13; k++) @(negedge clk);
        check("abort_pre_tx_bit2", {31'd0, bus4.tx_out}, 32'd0);
        #1;
        rst4 = 1'b1;
        #1;
        check("abort_reset_outputs",
              {23'd0, bus4.tx_out, bus4.ready_out, bus4.busy, bus4.done, bus4.par_err, bus4.frame_count},
              {23'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        rst4 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("abort_no_done_no_count", {23'd0, bus4.done, bus4.frame_count}, 32'd0);
        end
        v = '{d: 4'b0011, p: 1'b0, keep: 1'b0, bits: 7'b0110001, perr: 1'b0, cnt: 8'd1};
        run_frame(v, "after_abort");

        // C=1: 256 back-to-back frames, period 8, counter wraps to 0.
        pat   = 7'b0110001;
        errs  = 0;
        ndone = 0;
        @(negedge clk);
        bus1.d_in = 4'b0011; bus1.parity_in = 1'b0; bus1.valid_in = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            pos    = i % 8;
            exp_tx = (pos == 7) ? 1'b1 : pat[6-pos];
            if (bus1.tx_out !== exp_tx || bus1.done !== (pos == 7) || bus1.busy !== (pos != 7)) begin
                if (errs == 0)
                    $display("FAIL wrap_first_bad_cycle: cycle %0d tx %0b done %0b busy %0b expected tx %0b",
                             i, bus1.tx_out, bus1.done, bus1.busy, exp_tx);
                errs++;
            end
            if (bus1.done === 1'b1) ndone++;
            if (i == 2039) check("wrap_count_255", {24'd0, bus1.frame_count}, 32'd255);
            if (i == 2047) bus1.valid_in = 1'b0;
        end
        check("wrap_pattern_errors", errs, 32'd0);
        check("wrap_done_pulses", ndone, 32'd256);
        check("wrap_count_zero", {24'd0, bus1.frame_count}, 32'd0);
        @(negedge clk);
        check("wrap_idle_after", {29'd0, bus1.busy, bus1.ready_out, bus1.done}, 32'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
